// File: rtl/digest_serializer.sv
// Serialises a captured hash digest into 32-bit words with byte enables,
// last-word marking, backpressure and back-to-back digest chaining.
module digest_serializer #(
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned DIGEST_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    digest_valid,
    input  logic [DIGEST_WIDTH-1:0] digest,
    input  logic [6:0]              digest_bytes,
    output logic [BUS_WIDTH-1:0]    dout,
    output logic                    valid_out,
    input  logic                    dout_ready,
    output logic [BUS_WIDTH/8-1:0]  byte_en,
    output logic                    last_out,
    output logic                    busy,
    output logic                    overrun
);
    localparam int unsigned BytesPerWord = BUS_WIDTH / 8;
    localparam int unsigned MaxBytes     = DIGEST_WIDTH / 8;
    localparam int unsigned NumWords     = DIGEST_WIDTH / BUS_WIDTH;
    localparam int unsigned IdxW         = ($clog2(NumWords) > 5) ? $clog2(NumWords) : 5;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [DIGEST_WIDTH-1:0] data_q, data_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IdxW-1:0]         last_idx_q, last_idx_d;
    logic [BytesPerWord-1:0] last_be_q, last_be_d;
    logic                    overrun_q, overrun_d;

    int unsigned             req_len, eff_len, eff_rem;
    logic [IdxW-1:0]         load_last_idx;
    logic [BytesPerWord-1:0] load_last_be;
    logic                    load, xfer;

    // Effective length: out-of-range requests fall back to the full digest.
    always_comb begin
        req_len       = {25'd0, digest_bytes};
        eff_len       = (req_len >= 1 && req_len <= MaxBytes) ? req_len : MaxBytes;
        eff_rem       = eff_len % BytesPerWord;
        load_last_idx = IdxW'((eff_len + BytesPerWord - 1) / BytesPerWord - 1);
        load_last_be  = (eff_rem == 0) ? '1 : BytesPerWord'((32'd1 << eff_rem) - 1);
    end

    // Outputs depend only on registered state; the current word sits at the bottom of data_q.
    always_comb begin
        valid_out = (state_q == StSend);
        busy      = (state_q == StSend);
        last_out  = valid_out && (idx_q == last_idx_q);
        byte_en   = '0;
        if (valid_out) begin
            byte_en = last_out ? last_be_q : '1;
        end
        dout = '0;
        for (int i = 0; i < int'(BytesPerWord); i++) begin
            dout[8*i +: 8] = byte_en[i] ? data_q[8*i +: 8] : 8'h00;
        end
        overrun = overrun_q;
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        last_be_d  = last_be_q;
        overrun_d  = overrun_q;
        load       = 1'b0;
        xfer       = valid_out && dout_ready;
        unique case (state_q)
            StIdle: begin
                if (digest_valid) begin
                    load = 1'b1;
                end
            end
            StSend: begin
                if (xfer && last_out) begin
                    if (digest_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end else begin
                    if (digest_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (xfer) begin
                        idx_d  = idx_q + 1'b1;
                        data_d = data_q >> BUS_WIDTH;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            state_d    = StSend;
            data_d     = digest;
            idx_d      = '0;
            last_idx_d = load_last_idx;
            last_be_d  = load_last_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            data_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            last_be_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            last_be_q  <= last_be_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// Directed and randomized checks of digest_serializer against a byte-level
// model of the expected word stream.
module tb_digest_serializer;
    logic         clk = 1'b0;
    logic         reset;
    logic         digest_valid;
    logic [511:0] digest;
    logic [6:0]   digest_bytes;
    logic [31:0]  dout;
    logic         valid_out;
    logic         dout_ready;
    logic [3:0]   byte_en;
    logic         last_out;
    logic         busy;
    logic         overrun;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_ovr     = 1'b0;

    always #5 clk = ~clk;

    digest_serializer #(
        .BUS_WIDTH    (32),
        .DIGEST_WIDTH (512)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digest_valid (digest_valid),
        .digest       (digest),
        .digest_bytes (digest_bytes),
        .dout         (dout),
        .valid_out    (valid_out),
        .dout_ready   (dout_ready),
        .byte_en      (byte_en),
        .last_out     (last_out),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model: byte b of the stream is digest byte b when b < L, else a zero byte outside byte_en.
    function automatic int eff_len(input int nn);
        return (nn >= 1 && nn <= 64) ? nn : 64;
    endfunction

    function automatic logic [31:0] exp_word(input logic [511:0] d, input int len, input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            if (4 * k + j < len) w[8*j +: 8] = d[8*(4*k+j) +: 8];
        end
        return w;
    endfunction

    function automatic logic [3:0] exp_be(input int len, input int k);
        logic [3:0] b;
        for (int j = 0; j < 4; j++) b[j] = (4 * k + j < len);
        return b;
    endfunction

    function automatic logic [511:0] rand_digest();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, last_out, 0);
        chk({tag, "_be"}, byte_en, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_overrun"}, overrun, exp_ovr);
    endtask

    task automatic pulse(input logic [511:0] d, input int nn);
        digest_valid = 1'b1;
        digest       = d;
        digest_bytes = 7'(nn);
        @(negedge clk);
    endtask

    // Receives one digest; called on the negedge where word 0 must already be visible.
    task automatic recv(input string tag, input logic [511:0] d, input int nn,
                        input int stall_first, input bit rnd, input int ovr_k, input int rst_k,
                        input bit chain, input logic [511:0] nd, input int nnn,
                        output int cycles);
        int len, w, k;
        bit rdy, ovr_pend, ovr_done;
        len      = eff_len(nn);
        w        = (len + 3) / 4;
        k        = 0;
        cycles   = 0;
        ovr_done = 1'b0;
        while (k < w && cycles < 400) begin
            chk({tag, "_valid"}, valid_out, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_dout"}, dout, exp_word(d, len, k));
            chk({tag, "_be"}, byte_en, exp_be(len, k));
            chk({tag, "_last"}, last_out, (k == w - 1));
            chk({tag, "_overrun"}, overrun, exp_ovr);
            rdy = rnd ? ($urandom_range(0, 3) != 0) : (cycles >= stall_first);
            dout_ready   = rdy;
            digest_valid = 1'b0;
            ovr_pend     = 1'b0;
            if (k == rst_k) begin
                reset        = 1'b1;
                digest_valid = 1'b1;
                digest       = rand_digest();
                digest_bytes = 7'd64;
                @(negedge clk);
                reset        = 1'b0;
                digest_valid = 1'b0;
                exp_ovr      = 1'b0;
                idle_chk({tag, "_rst_abort"});
                @(negedge clk);
                idle_chk({tag, "_rst_discard"});
                return;
            end
            if (k == ovr_k && !ovr_done && k < w - 1) begin
                digest_valid = 1'b1;
                digest       = rand_digest();
                digest_bytes = 7'(nn);
                ovr_pend     = 1'b1;
                ovr_done     = 1'b1;
            end
            if (chain && rdy && k == w - 1) begin
                digest_valid = 1'b1;
                digest       = nd;
                digest_bytes = 7'(nnn);
            end
            @(negedge clk);
            if (ovr_pend) exp_ovr = 1'b1;
            if (rdy) k++;
            cycles++;
        end
        digest_valid = 1'b0;
        dout_ready   = 1'b1;
        chk({tag, "_words"}, k, w);
    endtask

    initial begin
        logic [511:0] d, d2;
        int cyc, nn;
        reset        = 1'b1;
        digest_valid = 1'b0;
        digest       = '0;
        digest_bytes = '0;
        dout_ready   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_chk("reset");

        // Full 64-byte digest with bytes 0x00..0x3F.
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        pulse(d, 64);
        recv("full", d, 64, 0, 0, -1, -1, 0, '0, 0, cyc);
        chk("full_cycles", cyc, 16);
        idle_chk("full_done");

        d = rand_digest();
        pulse(d, 11);
        recv("short", d, 11, 0, 0, -1, -1, 0, '0, 0, cyc);
        chk("short_cycles", cyc, 3);
        idle_chk("short_done");

        d = rand_digest();
        pulse(d, 8);
        recv("bp", d, 8, 5, 0, -1, -1, 0, '0, 0, cyc);
        chk("bp_cycles", cyc, 7);
        idle_chk("bp_done");

        // Back-to-back chain, then a mid-transfer pulse that must be dropped.
        d  = rand_digest();
        d2 = rand_digest();
        pulse(d, 20);
        recv("b2b_a", d, 20, 0, 0, -1, -1, 1, d2, 64, cyc);
        chk("b2b_a_cycles", cyc, 5);
        recv("b2b_b", d2, 64, 0, 0, 3, -1, 0, '0, 0, cyc);
        chk("b2b_b_cycles", cyc, 16);
        idle_chk("b2b_done");
        @(negedge clk);
        idle_chk("ovr_sticky");

        d = rand_digest();
        pulse(d, 0);
        recv("clamp0", d, 0, 0, 1, -1, -1, 0, '0, 0, cyc);
        idle_chk("clamp0_done");
        d = rand_digest();
        pulse(d, 100);
        recv("clamp100", d, 100, 0, 1, -1, -1, 0, '0, 0, cyc);
        idle_chk("clamp100_done");

        d = rand_digest();
        pulse(d, 64);
        recv("rst", d, 64, 0, 0, -1, 5, 0, '0, 0, cyc);
        d = rand_digest();
        pulse(d, 37);
        recv("post_rst", d, 37, 0, 0, -1, -1, 0, '0, 0, cyc);
        chk("post_rst_cycles", cyc, 10);
        idle_chk("post_rst_done");

        for (int t = 0; t < 20; t++) begin
            d  = rand_digest();
            nn = $urandom_range(0, 127);
            pulse(d, nn);
            recv("rand", d, nn, 0, 1, -1, -1, 0, '0, 0, cyc);
            idle_chk("rand_done");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digest_serializer.md
DIGEST_SERIALIZER -- requirements
Module: digest_serializer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, output word width in bits; only 32 is supported.
REQ-002 SHALL have parameter DIGEST_WIDTH, default 512, hash core digest width in bits; a multiple of BUS_WIDTH.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port list, one per line:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- digest_valid  input  1  one-cycle pulse from the hash core; digest is valid.
- digest  input  DIGEST_WIDTH  hash result, byte 0 in bits [7:0].
- digest_bytes  input  7  requested output length nn in bytes, sampled with digest_valid.
- dout  output  BUS_WIDTH  output word.
- valid_out  output  1  dout is valid.
- dout_ready  input  1  consumer accepts dout this cycle.
- byte_en  output  BUS_WIDTH/8  valid bytes within dout; bit i covers dout[8i+7:8i].
- last_out  output  1  marks the final word of a digest.
- busy  output  1  a digest is held or being sent.
- overrun  output  1  sticky flag: a digest was dropped.

Function
REQ-005 SHALL implement two states: IDLE and SEND.
REQ-006 In IDLE, digest_valid=1 SHALL:
- capture digest into an internal register;
- compute an effective length L: digest_bytes when it is 1..DIGEST_WIDTH/8, otherwise DIGEST_WIDTH/8;
- load the word count W = ceil(L/4);
- clear the word index;
- enter SEND in the next cycle.
REQ-007 In SEND:
- valid_out SHALL be 1;
- dout SHALL be word k of the captured digest, bits [32k+31:32k], where k is the word index;
- busy SHALL be 1.
REQ-008 A word SHALL transfer only in a cycle where valid_out=1 and dout_ready=1; the index then increments.
REQ-009 While valid_out=1 and dout_ready=0, dout, byte_en and last_out SHALL hold stable.
REQ-010 last_out SHALL be 1 exactly when k = W-1.
REQ-011 byte_en SHALL be 4'b1111 on every word except the last.
REQ-012 On the last word, byte_en SHALL be 4'b1111 when L mod 4 = 0; otherwise it SHALL have the low (L mod 4) bits set.
REQ-013 Bytes of dout outside byte_en SHALL be driven to 0.
REQ-014 When the last word transfers and digest_valid=0, the block SHALL return to IDLE: valid_out=0 and busy=0 in the next cycle.
REQ-015 When the last word transfers and digest_valid=1 in the same cycle, the new digest SHALL be captured and sent with no idle cycle: word 0 of the new digest appears in the next cycle.
REQ-016 digest_valid in SEND, other than the REQ-015 case, SHALL be ignored and SHALL set overrun=1; the digest being sent SHALL be unaffected.
REQ-017 overrun SHALL clear only on reset.
REQ-018 In IDLE, valid_out, last_out, byte_en and dout SHALL be 0.
REQ-019 The latency from a digest_valid pulse to the first valid_out=1 SHALL be exactly 1 cycle.
REQ-020 Sustained throughput SHALL be one word per cycle while dout_ready=1.
REQ-021 The word index SHALL be at least 5 bits wide and SHALL never exceed W-1.

Reset
REQ-022 With reset=1 at a rising edge, the next cycle SHALL show:
- state IDLE;
- valid_out=0, last_out=0, byte_en=0, dout=0;
- busy=0, overrun=0;
- word index 0.
REQ-023 Reset asserted during SEND SHALL abort the transfer with no further words; a digest_valid in the same cycle as reset SHALL be discarded.
REQ-024 No output SHALL depend combinationally on reset; reset takes effect only at the clock edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with dout_ready=1 unless stated:
- Full digest: digest_bytes=64, digest bytes 0x00..0x3F, one pulse -> 16 words on consecutive cycles; first dout=32'h03020100, last dout=32'h3F3E3D3C with last_out=1; busy=0 after.
- Short digest: digest_bytes=11 -> 3 words; the third has byte_en=4'b0111, dout[31:24]=0, last_out=1.
- Backpressure: digest_bytes=8, dout_ready=0 for 5 cycles, then 1 -> word 0 held stable for 5 cycles; then 2 words transfer; no word lost or duplicated.
- Back-to-back and overrun: a digest_valid in the last-word transfer cycle -> new word 0 on the next cycle with no gap; a digest_valid mid-transfer -> ignored and overrun=1 until reset.
- Length clamp: digest_bytes=0 and digest_bytes=100 -> 16 words each, last byte_en=4'b1111.
- Reset mid-transfer: reset during word 5 of 16 -> the next cycle shows valid_out=0, busy=0, overrun=0; a following digest restarts at word 0.
